// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// cpu_pkg : shared types and constants for the 5-stage pipeline
// Rev 1.0 : initial release
// ============================================================================
package cpu_pkg;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;

    localparam logic [3:0]  HALT_OPCODE_DEF = 4'hF;
    localparam logic [15:0] NOP_INSTR_DEF   = 16'h0000;

    typedef enum logic [0:0] {
        FS_RUN    = 1'b0,
        FS_HALTED = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic        valid;
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] pc_plus1;
    } if_id_t;

    function automatic logic [3:0] opcode_of(input logic [15:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// if_id_reg : IF/ID pipeline register with hold, flush and reset
// Rev 1.0 : initial release
// ============================================================================
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   hold,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t r_q;

    // Flush beats hold so a redirect during a stall still clears the stage.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_q.valid    <= 1'b0;
            r_q.instr    <= NOP_INSTR;
            r_q.pc       <= 16'h0000;
            r_q.pc_plus1 <= 16'h0000;
        end else if (!hold) begin
            r_q.valid    <= d.valid;
            r_q.instr    <= d.valid ? d.instr : NOP_INSTR;
            r_q.pc       <= d.pc;
            r_q.pc_plus1 <= d.pc_plus1;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// if_stage : instruction fetch - PC, redirect/stall/halt priority, IF/ID
// Rev 1.0 : initial release
// ============================================================================
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = HALT_OPCODE_DEF,
    parameter logic [15:0] NOP_INSTR   = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] im_addr,
    input  logic [15:0] im_rdata,
    output logic [15:0] pc,
    output logic        if_id_valid,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc,
    output logic [15:0] if_id_pc_plus1,
    output logic        halted
);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;
    logic [15:0]  r_pc;
    logic [15:0]  w_pc_nxt;
    logic [15:0]  w_pc_plus1;
    logic         w_hold;
    logic         w_flush;
    if_id_t       w_fetch;
    if_id_t       w_if_id;

    assign w_pc_plus1 = r_pc + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FS_RUN;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // Priority: redirect > halted bubble > stall > halt detect > fetch.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_hold           = 1'b0;
        w_flush          = 1'b0;
        w_fetch.valid    = 1'b1;
        w_fetch.instr    = im_rdata;
        w_fetch.pc       = r_pc;
        w_fetch.pc_plus1 = w_pc_plus1;
        if (redirect) begin
            w_pc_nxt    = redirect_pc;
            w_flush     = 1'b1;
            w_state_nxt = FS_RUN;
        end else if (r_state == FS_HALTED) begin
            w_flush = 1'b1;
        end else if (stall) begin
            w_hold = 1'b1;
        end else if (opcode_of(im_rdata) == HALT_OPCODE) begin
            w_state_nxt = FS_HALTED;
        end else begin
            w_pc_nxt = w_pc_plus1;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk   (clk),
        .rst   (rst),
        .hold  (w_hold),
        .flush (w_flush),
        .d     (w_fetch),
        .q     (w_if_id)
    );

    assign im_addr        = r_pc;
    assign pc             = r_pc;
    assign halted         = (r_state == FS_HALTED);
    assign if_id_valid    = w_if_id.valid;
    assign if_id_instr    = w_if_id.instr;
    assign if_id_pc       = w_if_id.pc;
    assign if_id_pc_plus1 = w_if_id.pc_plus1;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// tb_if_stage : directed + randomized bench for if_stage against a fetch model
// Rev 1.0 : initial release
// ============================================================================
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] mem [0:65535];

    logic [15:0] im_addr, im_rdata, pc, if_id_instr, if_id_pc, if_id_pc_plus1;
    logic        if_id_valid, halted;
    logic [15:0] w_im_addr, w_im_rdata, w_pc, w_if_id_instr, w_if_id_pc, w_if_id_pc_plus1;
    logic        w_if_id_valid, w_halted;

    int checks = 0;
    int errors = 0;

    assign im_rdata   = mem[im_addr];
    assign w_im_rdata = mem[w_im_addr];

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .im_addr(im_addr), .im_rdata(im_rdata), .pc(pc), .if_id_valid(if_id_valid),
        .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_pc_plus1(if_id_pc_plus1),
        .halted(halted)
    );

    if_stage #(.RESET_PC(16'hFFFE)) dut_w (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .im_addr(w_im_addr), .im_rdata(w_im_rdata), .pc(w_pc), .if_id_valid(w_if_id_valid),
        .if_id_instr(w_if_id_instr), .if_id_pc(w_if_id_pc), .if_id_pc_plus1(w_if_id_pc_plus1),
        .halted(w_halted)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: [0] tracks dut, [1] tracks dut_w.
    logic        m_init = 1'b0;
    logic [15:0] m_pc     [2];
    logic        m_halted [2];
    logic        m_valid  [2];
    logic [15:0] m_instr  [2];
    logic [15:0] m_ipc    [2];
    logic [15:0] m_ipc1   [2];
    logic        m_known  [2];

    task automatic model_step(input int k);
        logic [15:0] word;
        if (rst) begin
            m_pc[k]     = (k == 0) ? 16'h0000 : 16'hFFFE;
            m_halted[k] = 1'b0;
            m_valid[k]  = 1'b0;
            m_instr[k]  = 16'h0000;
            m_ipc[k]    = 16'h0000;
            m_ipc1[k]   = 16'h0000;
            m_known[k]  = 1'b1;
        end else if (redirect) begin
            m_pc[k]     = redirect_pc;
            m_halted[k] = 1'b0;
            m_valid[k]  = 1'b0;
            m_instr[k]  = 16'h0000;
            m_ipc[k]    = 16'h0000;
            m_ipc1[k]   = 16'h0000;
            m_known[k]  = 1'b1;
        end else if (m_halted[k]) begin
            m_valid[k] = 1'b0;
            m_instr[k] = 16'h0000;
            m_known[k] = 1'b0;
        end else if (!stall) begin
            word       = mem[m_pc[k]];
            m_valid[k] = 1'b1;
            m_instr[k] = word;
            m_ipc[k]   = m_pc[k];
            m_ipc1[k]  = m_pc[k] + 16'd1;
            m_known[k] = 1'b1;
            if (word[15:12] == 4'hF) m_halted[k] = 1'b1;
            else                     m_pc[k]     = m_pc[k] + 16'd1;
        end
    endtask

    always @(posedge clk) begin
        if (rst) m_init = 1'b1;
        if (m_init) begin
            for (int k = 0; k < 2; k++) model_step(k);
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("pc", pc, m_pc[0]);
            chk("im_addr", im_addr, m_pc[0]);
            chk("halted", 16'(halted), 16'(m_halted[0]));
            chk("valid", 16'(if_id_valid), 16'(m_valid[0]));
            chk("instr", if_id_instr, m_instr[0]);
            if (m_known[0]) begin
                chk("if_id_pc", if_id_pc, m_ipc[0]);
                chk("if_id_pc_plus1", if_id_pc_plus1, m_ipc1[0]);
            end
            chk("w_pc", w_pc, m_pc[1]);
            chk("w_halted", 16'(w_halted), 16'(m_halted[1]));
            chk("w_valid", 16'(w_if_id_valid), 16'(m_valid[1]));
            chk("w_instr", w_if_id_instr, m_instr[1]);
            if (m_known[1]) begin
                chk("w_if_id_pc", w_if_id_pc, m_ipc[1]);
                chk("w_if_id_pc_plus1", w_if_id_pc_plus1, m_ipc1[1]);
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] word;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
        mem[0] = 16'h1123; mem[1] = 16'h2456; mem[2] = 16'h3789;
        mem[3] = 16'h4ABC; mem[4] = 16'h5DEF; mem[16'h10] = 16'h7777;
        cyc(); cyc();
        chk("lit_rst_pc", pc, 16'h0000);
        chk("lit_rst_valid", 16'(if_id_valid), 16'h0);
        chk("lit_rst_instr", if_id_instr, 16'h0000);
        chk("lit_rst_halted", 16'(halted), 16'h0);
        chk("lit_rst_w_pc", w_pc, 16'hFFFE);

        rst = 1'b0;
        cyc();
        chk("lit_f0_instr", if_id_instr, 16'h1123);
        chk("lit_f0_pc", if_id_pc, 16'h0000);
        chk("lit_f0_pc1", if_id_pc_plus1, 16'h0001);
        chk("lit_f0_valid", 16'(if_id_valid), 16'h1);
        chk("lit_wrap0", w_if_id_pc, 16'hFFFE);
        cyc();
        chk("lit_f1_instr", if_id_instr, 16'h2456);
        chk("lit_f1_pc1", if_id_pc_plus1, 16'h0002);
        chk("lit_f1_nextpc", pc, 16'h0002);
        chk("lit_wrap1", w_if_id_pc, 16'hFFFF);
        chk("lit_wrap1_pc1", w_if_id_pc_plus1, 16'h0000);
        stall = 1'b1;
        repeat (2) begin
            cyc();
            chk("lit_stall_addr", im_addr, 16'h0002);
            chk("lit_stall_instr", if_id_instr, 16'h2456);
        end
        stall = 1'b0;
        cyc();
        chk("lit_f2_instr", if_id_instr, 16'h3789);
        chk("lit_f2_pc", if_id_pc, 16'h0002);
        chk("lit_wrap2", w_if_id_pc, 16'h0000);
        cyc();
        chk("lit_f3_instr", if_id_instr, 16'h4ABC);
        chk("lit_f3_pc1", if_id_pc_plus1, 16'h0004);
        cyc();
        chk("lit_pc5", pc, 16'h0005);

        redirect = 1'b1; redirect_pc = 16'h0010;
        cyc();
        chk("lit_rd_pc", pc, 16'h0010);
        chk("lit_rd_valid", 16'(if_id_valid), 16'h0);
        chk("lit_rd_instr", if_id_instr, 16'h0000);
        redirect = 1'b0;
        cyc();
        chk("lit_rd_fetch", if_id_instr, 16'h7777);
        chk("lit_rd_fetch_pc", if_id_pc, 16'h0010);

        mem[3] = 16'hF000; mem[16'h20] = 16'h2222;
        redirect = 1'b1; redirect_pc = 16'h0000;
        cyc();
        redirect = 1'b0;
        repeat (4) cyc();
        chk("lit_halt_instr", if_id_instr, 16'hF000);
        chk("lit_halt_valid", 16'(if_id_valid), 16'h1);
        chk("lit_halt_pc", pc, 16'h0003);
        chk("lit_halt_flag", 16'(halted), 16'h1);
        for (int i = 0; i < 12; i++) begin
            stall = i[0];
            cyc();
            chk("lit_halted_flag", 16'(halted), 16'h1);
            chk("lit_halted_pc", pc, 16'h0003);
            chk("lit_halted_valid", 16'(if_id_valid), 16'h0);
        end
        stall = 1'b0; redirect = 1'b1; redirect_pc = 16'h0020;
        cyc();
        chk("lit_unhalt_flag", 16'(halted), 16'h0);
        chk("lit_unhalt_pc", pc, 16'h0020);
        redirect = 1'b0;
        cyc();
        chk("lit_unhalt_instr", if_id_instr, 16'h2222);
        chk("lit_unhalt_ipc", if_id_pc, 16'h0020);

        mem[16'h40] = 16'hF123;
        stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0040;
        cyc();
        chk("lit_rdst_pc", pc, 16'h0040);
        chk("lit_rdst_valid", 16'(if_id_valid), 16'h0);
        stall = 1'b0; redirect = 1'b0;
        cyc();
        chk("lit_halt2", 16'(halted), 16'h1);
        cyc();
        rst = 1'b1;
        cyc();
        chk("lit_rsth_pc", pc, 16'h0000);
        chk("lit_rsth_halted", 16'(halted), 16'h0);
        chk("lit_rsth_valid", 16'(if_id_valid), 16'h0);
        rst = 1'b0;
        cyc(); cyc();
        stall = 1'b1;
        cyc();
        rst = 1'b1;
        cyc();
        chk("lit_rsts_pc", pc, 16'h0000);
        chk("lit_rsts_valid", 16'(if_id_valid), 16'h0);
        rst = 1'b0; stall = 1'b0;

        for (int a = 0; a < 65536; a++) begin
            word = 16'($urandom);
            if (word[15:12] == 4'hF && $urandom_range(3, 0) != 0) word[15:12] = 4'h1;
            mem[a] = word;
        end
        for (int n = 0; n < 3000; n++) begin
            cyc();
            rst         = ($urandom_range(99, 0) == 0);
            redirect    = ($urandom_range(9, 0) == 0);
            stall       = ($urandom_range(3, 0) == 0);
            redirect_pc = ($urandom_range(1, 0) == 0) ? 16'($urandom_range(300, 0))
                                                      : 16'($urandom);
        end
        rst = 1'b0; redirect = 1'b0; stall = 1'b0;
        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
